// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clock cycles per bit, truncated.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: valid/ready byte plus error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        input  ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_sync.sv
// RX line conditioning: 2-FF synchronizer, 3-sample history, majority vote
// and falling-edge flag. Everything resets to 0 so a line held low through
// reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_bit,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic [1:0] r_hist;  // [0] = rx_s one cycle ago, [1] = two cycles ago

    // Synchronize the line and keep the last two synchronized samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= '0;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_hist <= {r_hist[0], r_sync};
        end
    end

    assign o_bit  = (r_sync & r_hist[0]) | (r_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
    assign o_fall = r_hist[0] & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a one-byte holding register on a
// valid/ready handshake and single-cycle frame-error / overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned RX_BAUD  = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned BIT_CNT  = cycles_per_bit(CLK_FREQ, RX_BAUD);
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CNT);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    rx_state_t            r_state, w_state_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [IDX_W-1:0]     r_idx, w_idx_n;
    logic [DATA_BITS-1:0] r_shift, w_shift_n;
    logic                 w_stop_good, w_stop_bad;
    logic                 w_bit, w_fall;
    logic                 w_load, w_accept;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_ferr, r_ovr;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_rx   (rx),
        .o_bit  (w_bit),
        .o_fall (w_fall)
    );

    // Frame state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
        end
    end

    // Next-state: sample mid-bit, shift data in LSB first, judge the stop bit.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + 1'b1;
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (w_fall) w_state_n = START;
            end
            START: begin
                if (r_cnt == CNT_HALF_END) begin
                    w_cnt_n = '0;
                    if (!w_bit) begin
                        w_state_n = DATA;
                        w_idx_n   = '0;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_bit, r_shift[DATA_BITS-1:1]};
                    w_idx_n   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) w_state_n = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_n     = '0;
                    w_state_n   = IDLE;
                    w_stop_good = (w_bit == LINE_IDLE);
                    w_stop_bad  = (w_bit != LINE_IDLE);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // A completed byte may land in the same cycle the old one is accepted.
    assign w_accept = r_valid && bus.ready;
    assign w_load   = w_stop_good && (!r_valid || bus.ready);

    // Holding register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_ovr  <= w_stop_good && !w_load;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;

    // Fewer than 8 clocks per bit cannot hold the sync + majority window.
    if (BIT_CNT < 8) begin : g_bad_cfg
        always_ff @(posedge clk) begin
            assert (1'b0) else $error("uart_rx: BIT_CNT=%0d is below 8", BIT_CNT);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, hand-written corner sequences and a
// randomized run checked against a frame-level holding-register model.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 3_686_400;
    localparam int unsigned RX_BAUD  = 115_200;
    localparam int unsigned BIT      = CLK_FREQ / RX_BAUD;   // 32
    localparam int unsigned HALF     = BIT / 2;
    localparam int unsigned LAT_MIN  = (BIT * 19) / 2;       // 9.5 bit times
    localparam int unsigned LAT_MAX  = LAT_MIN + 6;          // sync + edge slack

    localparam int EV_ACC = 'h100;
    localparam int EV_FE  = 'h200;
    localparam int EV_OVR = 'h300;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .RX_BAUD  (RX_BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    // Observed consumer-side events.
    int          fe_cnt = 0, ovr_cnt = 0, acc_cnt = 0, rise_cnt = 0, vfall_cnt = 0;
    int unsigned last_rise_cyc = 0;
    logic        prev_valid = 1'b0;
    bit          rec_en = 1'b0;
    int          obs_q[$];
    int          exp_q[$];

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) begin
            fe_cnt++;
            if (rec_en) obs_q.push_back(EV_FE);
        end
        if (bus.overrun === 1'b1) begin
            ovr_cnt++;
            if (rec_en) obs_q.push_back(EV_OVR);
        end
        if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
            acc_cnt++;
            if (rec_en) obs_q.push_back(EV_ACC | int'(bus.data));
        end
        if (bus.valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (bus.valid !== 1'b1 && prev_valid === 1'b1) vfall_cnt++;
        prev_valid = bus.valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Move to a quiet sampling point, then back to the drive point afterwards.
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic resume();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int unsigned tail_low, output int unsigned t0);
        rx = 1'b0;
        t0 = cyc;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop;
        tick(BIT);
        if (tail_low != 0) begin
            rx = 1'b0;
            tick(tail_low);
        end
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_bit;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_ovr;
        int         exp_acc;
        bit         chk_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, lat, lat_ref;
        int          fe0, ovr0, acc0, rise0, vf0;
        logic [7:0]  hold;
        bit          full;

        tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 0, 0, 1, 1'b1};
        tbl[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 8'hA3, 0, 0, 1, 1'b1};
        tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'hA3, 1, 0, 0, 1'b0};
        tbl[3] = '{8'h3D, 1'b1, 1'b1, 1'b0, 8'h3D, 0, 0, 1, 1'b1};
        tbl[4] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 0, 1'b1};
        tbl[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1, 0, 1'b0};
        lat_ref = LAT_MIN + 3;

        // Reset state.
        rst = 1'b1;
        rx = 1'b1;
        bus.ready = 1'b0;
        tick(3);
        sample();
        check("reset_data", 32'(bus.data), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check("reset_overrun", 32'(bus.overrun), 32'h0);
        resume();
        rst = 1'b0;
        tick(BIT);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            bus.ready = tbl[i].rdy;
            tick(2);
            fe0 = fe_cnt; ovr0 = ovr_cnt; acc0 = acc_cnt; rise0 = rise_cnt;
            send_frame(tbl[i].byte_v, tbl[i].stop_bit, 0, t0);
            tick(4);
            sample();
            check($sformatf("row%0d_valid", i), 32'(bus.valid), 32'(tbl[i].exp_valid));
            check($sformatf("row%0d_data", i), 32'(bus.data), 32'(tbl[i].exp_data));
            check($sformatf("row%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(tbl[i].exp_fe));
            check($sformatf("row%0d_overrun", i), 32'(ovr_cnt - ovr0), 32'(tbl[i].exp_ovr));
            check($sformatf("row%0d_accepts", i), 32'(acc_cnt - acc0), 32'(tbl[i].exp_acc));
            if (tbl[i].chk_lat) begin
                lat = last_rise_cyc - t0;
                if (i == 0) lat_ref = lat;
                n_vec++;
                if (rise_cnt - rise0 != 1 || lat < LAT_MIN || lat > LAT_MAX) begin
                    n_miss++;
                    $display("FAIL row%0d_latency: got %0d cycles (%0d rises), expected %0d..%0d",
                             i, lat, rise_cnt - rise0, LAT_MIN, LAT_MAX);
                end
            end
            resume();
            tick(BIT);
        end

        // Draining the held byte: accepted this cycle, valid low next cycle.
        acc0 = acc_cnt;
        bus.ready = 1'b1;
        sample();
        check("drain_valid_same_cycle", 32'(bus.valid), 32'h1);
        check("drain_accept", 32'(acc_cnt - acc0), 32'h1);
        resume();
        sample();
        check("drain_valid_drop", 32'(bus.valid), 32'h0);
        resume();
        tick(BIT);

        // Break: stop bit low and the line stays low afterwards.
        fe0 = fe_cnt; acc0 = acc_cnt; rise0 = rise_cnt;
        send_frame(8'h3C, 1'b0, 3 * BIT, t0);
        tick(2 * BIT);
        sample();
        check("break_frame_err_once", 32'(fe_cnt - fe0), 32'h1);
        check("break_no_byte", 32'(rise_cnt - rise0), 32'h0);
        resume();
        acc0 = acc_cnt;
        send_frame(8'h3D, 1'b1, 0, t0);
        tick(4);
        sample();
        check("after_break_data", 32'(bus.data), 32'h3D);
        check("after_break_accept", 32'(acc_cnt - acc0), 32'h1);
        resume();
        tick(BIT);

        // Short low glitch, then a frame as soon as the receiver should be idle.
        fe0 = fe_cnt; acc0 = acc_cnt; rise0 = rise_cnt;
        rx = 1'b0;
        tick(8);
        rx = 1'b1;
        tick(HALF - 2);
        sample();
        check("glitch_no_valid", 32'(rise_cnt - rise0), 32'h0);
        resume();
        tick(8);
        send_frame(8'h5A, 1'b1, 0, t0);
        tick(4);
        sample();
        check("glitch_frame_err", 32'(fe_cnt - fe0), 32'h0);
        check("glitch_next_data", 32'(bus.data), 32'h5A);
        check("glitch_next_rises", 32'(rise_cnt - rise0), 32'h1);
        resume();
        tick(BIT);

        // Back-to-back with ready raised exactly in the landing cycle.
        bus.ready = 1'b0;
        tick(2);
        send_frame(8'h66, 1'b1, 0, t0);
        sample();
        check("b2b_first_valid", 32'(bus.valid), 32'h1);
        check("b2b_first_data", 32'(bus.data), 32'h66);
        resume();
        ovr0 = ovr_cnt; acc0 = acc_cnt; vf0 = vfall_cnt;
        fork
            send_frame(8'h99, 1'b1, 0, t0);
            begin
                tick(lat_ref - 1);
                bus.ready = 1'b1;
                tick(1);
                bus.ready = 1'b0;
            end
        join
        tick(4);
        sample();
        check("b2b_data", 32'(bus.data), 32'h99);
        check("b2b_valid", 32'(bus.valid), 32'h1);
        check("b2b_no_overrun", 32'(ovr_cnt - ovr0), 32'h0);
        check("b2b_valid_never_dropped", 32'(vfall_cnt - vf0), 32'h0);
        check("b2b_accept", 32'(acc_cnt - acc0), 32'h1);
        resume();
        bus.ready = 1'b1;
        tick(4);

        // Reset during bit 4 with the line held low through release.
        fe0 = fe_cnt; rise0 = rise_cnt;
        rx = 1'b0;
        tick(BIT + 4 * BIT + HALF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3 * BIT);
        sample();
        check("midrst_data", 32'(bus.data), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_frame_err", 32'(fe_cnt - fe0), 32'h0);
        check("midrst_no_byte", 32'(rise_cnt - rise0), 32'h0);
        resume();
        rx = 1'b1;
        tick(BIT);
        acc0 = acc_cnt;
        send_frame(8'hF0, 1'b1, 0, t0);
        tick(4);
        sample();
        check("midrst_next_data", 32'(bus.data), 32'hF0);
        check("midrst_next_accept", 32'(acc_cnt - acc0), 32'h1);
        resume();
        tick(BIT);

        // Randomized frames against a frame-level holding-register model.
        full = 1'b0;
        hold = '0;
        rec_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b;
            logic       stop, r;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            r    = 1'($urandom_range(0, 1));
            bus.ready = r;
            tick(2);
            send_frame(b, stop, 0, t0);
            tick($urandom_range(1, 3) * BIT);
            if (r && full) begin
                exp_q.push_back(EV_ACC | int'(hold));
                full = 1'b0;
            end
            if (!stop) begin
                exp_q.push_back(EV_FE);
            end else if (full) begin
                exp_q.push_back(EV_OVR);
            end else begin
                hold = b;
                full = 1'b1;
                if (r) begin
                    exp_q.push_back(EV_ACC | int'(b));
                    full = 1'b0;
                end
            end
        end
        bus.ready = 1'b1;
        tick(4);
        if (full) exp_q.push_back(EV_ACC | int'(hold));
        rec_en = 1'b0;
        check("rand_event_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("rand_event%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
